// File: rtl/pool1_pkg.sv
// pool1_pkg: shared pixel types, sizes and lane-wise max helper for the pool1 path.
package pool1_pkg;
  localparam int bits = 16;
  localparam int channel_num = 16;
  localparam int pix_w = bits * channel_num;
  localparam int def_in_length = 96;
  localparam int def_in_height = 252;
  typedef logic [pix_w-1:0] pixel_t;
  typedef logic signed [bits-1:0] lane_t;
  typedef enum logic [1:0] {IDLE, STROBE, HOLD, GAP} tx_state_t;
  function automatic pixel_t pix_max(pixel_t a, pixel_t b);
    pixel_t m;
    for (int k = 0; k < channel_num; k++) begin
      m[k*bits +: bits] = $signed(a[k*bits +: bits]) > $signed(b[k*bits +: bits]) ? a[k*bits +: bits] : b[k*bits +: bits];
    end
    return m;
  endfunction
endpackage

// File: rtl/pool1_tx_fifo.sv
// pool1_tx_fifo: pooled-pixel FIFO with fall-through head and free-slot count.
module pool1_tx_fifo
  import pool1_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    wr_en,
  input  pixel_t                  wr_data,
  input  logic                    rd_en,
  output pixel_t                  rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  free_cnt
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] dep = (aw+1)'(depth);
  pixel_t mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] cnt;
  logic wr, rd;
  assign full = cnt == dep;
  assign empty = cnt == '0;
  assign free_cnt = dep - cnt;
  assign rd_data = mem[rd_ptr];
  assign wr = wr_en & ~full;
  assign rd = rd_en & ~empty;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (aw+1)'(wr) - (aw+1)'(rd);
    end
  end
  always_ff @(posedge clk_in) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/pool1_pool_tx.sv
// pool1_pool_tx: 2x2/2 max pooling of the conv1 stream, strobed out to the pool1 buffer.
module pool1_pool_tx
  import pool1_pkg::*;
#(
  parameter int in_length = def_in_length,
  parameter int in_height = def_in_height,
  parameter int hold_cycles = 5,
  parameter int gap_cycles = 1,
  parameter int fifo_depth = 4
) (
  input  logic   clk_in,
  input  logic   rst,
  input  logic   in_valid,
  input  pixel_t in_data,
  output logic   in_ready,
  output logic   start,
  output pixel_t data_out,
  output logic   frame_done
);
  localparam int cw = $clog2(in_length);
  localparam int rw = $clog2(in_height);
  localparam int fw = $clog2(fifo_depth) + 1;
  localparam int total = (in_length / 2) * (in_height / 2);
  localparam int pw = $clog2(total);
  localparam logic [cw-1:0] col_last = cw'(in_length - 1);
  localparam logic [rw-1:0] row_last = rw'(in_height - 1);
  localparam logic [pw-1:0] px_last = pw'(total - 1);
  localparam logic [7:0] hc_last = 8'(hold_cycles - 1);
  localparam logic [7:0] gc_last = 8'(gap_cycles - 1);
  logic [cw-1:0] col;
  logic [rw-1:0] row;
  logic [cw-2:0] idx;
  pixel_t hold, pair, pooled, head;
  pixel_t rowmem [in_length/2];
  logic acc, pool_vld, pop, full, empty, last_px;
  logic [fw-1:0] free_cnt;
  logic [pw-1:0] px_cnt;
  logic [7:0] cnt, cnt_nxt;
  tx_state_t state, state_nxt;
  // one spare slot covers the pooled register that may push next cycle
  assign in_ready = ~full & (free_cnt >= fw'(2));
  assign acc = in_valid & in_ready;
  assign idx = col[cw-1:1];
  assign pair = pix_max(hold, in_data);
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      hold <= '0;
      pooled <= '0;
      pool_vld <= 1'b0;
    end else begin
      pool_vld <= acc & col[0] & row[0];
      if (acc) begin
        col <= col == col_last ? '0 : col + 1'b1;
        if (col == col_last) row <= row == row_last ? '0 : row + 1'b1;
        if (!col[0]) hold <= in_data;
        if (col[0] & row[0]) pooled <= pix_max(pair, rowmem[idx]);
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (acc & col[0] & ~row[0]) rowmem[idx] <= pair;
  end
  pool1_tx_fifo #(.depth(fifo_depth)) u_fifo (
    .clk_in   (clk_in),
    .rst      (rst),
    .wr_en    (pool_vld),
    .wr_data  (pooled),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .free_cnt (free_cnt)
  );
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      data_out <= '0;
      px_cnt <= '0;
      last_px <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (pop) begin
        data_out <= head;
        last_px <= px_cnt == px_last;
        px_cnt <= px_cnt == px_last ? '0 : px_cnt + 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    pop = 1'b0;
    start = 1'b0;
    unique case (state)
      IDLE: begin
        pop = ~empty;
        state_nxt = empty ? IDLE : STROBE;
      end
      STROBE: begin
        start = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        cnt_nxt = cnt == hc_last ? '0 : cnt + 1'b1;
        state_nxt = cnt == hc_last ? GAP : HOLD;
      end
      GAP: begin
        cnt_nxt = cnt == gc_last ? '0 : cnt + 1'b1;
        state_nxt = cnt == gc_last ? IDLE : GAP;
      end
    endcase
    frame_done = start & last_px;
  end
endmodule

// File: tb/tb_pool1_pool_tx.sv
// tb_pool1_pool_tx: directed and random frames on a reduced 8x4 geometry against a max-pool model.
module tb_pool1_pool_tx;
  import pool1_pkg::*;
  localparam int il = 8;
  localparam int ih = 4;
  localparam int np = il * ih;
  localparam int npool = (il / 2) * (ih / 2);
  localparam int hc = 5;
  logic clk = 0, rst = 1, in_valid = 0;
  logic in_ready, start, frame_done;
  pixel_t in_data = '0;
  pixel_t data_out, stab_val;
  pixel_t exp_q[$], got_q[$];
  pixel_t fr [np];
  int checks = 0, failures = 0, cyc = 0;
  int sidx = 0, last_st = -1000, min_gap = 1000, stab = 0, fd_total = 0;
  int ready_low = 0, acc9 = -1, first_st = -1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pool1_pool_tx #(.in_length(il), .in_height(ih)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .data_out   (data_out),
    .frame_done (frame_done)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic pixel_t ref_pool(int r, int c);
    pixel_t m;
    int best, v;
    for (int k = 0; k < channel_num; k++) begin
      best = -32768;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          v = $signed(fr[(2*r+dr)*il + 2*c + dc][16*k +: 16]);
          if (v > best) best = v;
        end
      m[16*k +: 16] = best[15:0];
    end
    return m;
  endfunction
  task automatic load_exp();
    for (int r = 0; r < ih/2; r++)
      for (int c = 0; c < il/2; c++) exp_q.push_back(ref_pool(r, c));
  endtask
  task automatic rand_frame();
    for (int i = 0; i < np; i++)
      for (int k = 0; k < channel_num; k++) fr[i][16*k +: 16] = 16'($urandom);
  endtask
  task automatic send(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      @(negedge clk);
      in_valid = 1;
      in_data = fr[i];
      while (!in_ready && w < 200) begin
        ready_low++;
        w++;
        @(negedge clk);
      end
      if (w >= 200) chk("ready_bound", w, 0);
      if (i == il + 1) acc9 = cyc;
    end
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_out(input int n);
    int w = 0;
    while (got_q.size() < n && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (12) @(negedge clk);
    chk("out_count", got_q.size(), n);
  endtask
  always @(posedge rst) begin
    exp_q.delete();
    got_q.delete();
    sidx = 0;
    stab = 0;
    last_st = -1000;
    first_st = -1;
  end
  // strobe monitor: scoreboard, frame_done position, spacing and hold-window stability
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_total++;
      if (stab > 0) begin
        chk("hold_stable", data_out, stab_val);
        chk("start_low", start, 0);
        stab--;
      end
      if (start) begin
        got_q.push_back(data_out);
        chk("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("pool_data", data_out, exp_q.pop_front());
        chk("frame_done", frame_done, sidx == npool - 1);
        sidx = (sidx == npool - 1) ? 0 : sidx + 1;
        if (cyc - last_st < min_gap) min_gap = cyc - last_st;
        if (first_st < 0) first_st = cyc;
        last_st = cyc;
        stab = hc;
        stab_val = data_out;
      end
    end
  end
  initial begin
    for (int i = 0; i < np; i++) fr[i] = {channel_num{16'h8000}};
    for (int i = 2*il; i < np; i++)
      for (int k = 0; k < channel_num; k++) fr[i][16*k +: 16] = 16'($urandom);
    fr[0][15:0] = 16'd3;
    fr[1][15:0] = 16'hFFF9;
    fr[il][15:0] = 16'd9;
    fr[il+1][15:0] = 16'd2;
    fr[2][95:80] = 16'hFFFF;
    fr[3][95:80] = 16'hFFFE;
    fr[il+2][95:80] = 16'hFFFD;
    fr[il+3][95:80] = 16'h8000;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_ready", in_ready, 1);
    rst = 0;
    load_exp();
    send(np);
    wait_out(npool);
    chk("w0_lane0", got_q[0][15:0], 16'd9);
    chk("w0_lane1", got_q[0][31:16], 16'h8000);
    chk("w0_lane15", got_q[0][255:240], 16'h8000);
    chk("w1_lane5", got_q[1][95:80], 16'hFFFF);
    chk("w1_lane0", got_q[1][15:0], 16'h8000);
    chk("fd_a", fd_total, 1);
    chk("backpressure", ready_low > 0, 1);
    rand_frame();
    got_q.delete();
    load_exp();
    send(np);
    wait_out(npool);
    chk("fd_b", fd_total, 2);
    rand_frame();
    load_exp();
    send(il + 6);
    #2 rst = 1;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_fdone", frame_done, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    rand_frame();
    load_exp();
    send(np);
    wait_out(npool);
    chk("fd_d", fd_total, 3);
    chk("latency", first_st - acc9, 3);
    chk("min_gap", min_gap, 8);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
